// File: rtl/imem_loadable.sv
// imem_loadable: loadable synchronous instruction memory (DEPTH x 32).
//   After reset it overwrites every word with FILL (CLEAR), then serves
//   fetches with a one-cycle registered read (RUN). A program image can be
//   streamed in over the ld_* handshake starting at word 0 (LOAD).
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   f_req, A          fetch request and byte address
//   f_ready           fetch accepted this cycle when high (RUN)
//   RD, f_rvalid      registered instruction, valid for one cycle
//   f_fault           00 ok, 01 misaligned, 10 out of range
//   ld_start          pulse in RUN to begin a load at word 0
//   ld_valid/ld_data  load beat; ld_last marks the final beat
//   ld_ready          load beats accepted (LOAD)
//   busy              not in RUN
module imem_loadable #(
  parameter int          DEPTH = 64,
  parameter int          AW    = 32,
  parameter logic [31:0] FILL  = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] A,
  output logic          f_ready,
  output logic [31:0]   RD,
  output logic          f_rvalid,
  output logic [1:0]    f_fault,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          busy
);
  localparam int LW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_t;

  state_t        r_state, w_state_nxt;
  logic [LW-1:0] r_wp, w_wp_nxt;
  logic          w_we;
  logic [31:0]   w_wdata;
  logic          w_wp_last;
  logic [31:0]   r_mem [DEPTH];

  logic          r_busy, r_fready, r_ldready;
  logic [31:0]   r_rd;
  logic          r_rvalid;
  logic [1:0]    r_fault;

  logic          w_acc, w_mis, w_oor;
  logic [1:0]    w_fault;
  logic [LW-1:0] w_ridx;

  assign w_wp_last = (r_wp == LW'(DEPTH - 1));

  // Next-state, write pointer and write-port control
  always_comb begin
    w_state_nxt = r_state;
    w_wp_nxt    = r_wp;
    w_we        = 1'b0;
    w_wdata     = FILL;
    case (r_state)
      S_CLEAR: begin
        w_we = 1'b1;
        if (w_wp_last) begin
          w_wp_nxt    = '0;
          w_state_nxt = S_RUN;
        end else begin
          w_wp_nxt = r_wp + 1'b1;
        end
      end
      S_RUN: begin
        if (ld_start) begin
          w_wp_nxt    = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          w_we    = 1'b1;
          w_wdata = ld_data;
          // A full-depth image ends the load even without ld_last
          if (ld_last || w_wp_last) begin
            w_wp_nxt    = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_wp_nxt = r_wp + 1'b1;
          end
        end
      end
      default: begin
        w_wp_nxt    = '0;
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  // State register; status outputs are registered decodes of the next state
  // so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_wp      <= '0;
      r_busy    <= 1'b1;
      r_fready  <= 1'b0;
      r_ldready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wp      <= w_wp_nxt;
      r_busy    <= (w_state_nxt != S_RUN);
      r_fready  <= (w_state_nxt == S_RUN);
      r_ldready <= (w_state_nxt == S_LOAD);
    end
  end

  // Storage is not reset; CLEAR rewrites every word after each reset.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wp] <= w_wdata;
  end

  // Fetch decode; misaligned takes priority over out-of-range
  assign w_acc   = f_req & r_fready;
  assign w_mis   = |A[1:0];
  assign w_oor   = |(A >> (LW + 2));
  assign w_fault = w_mis ? 2'b01 : (w_oor ? 2'b10 : 2'b00);
  assign w_ridx  = A[LW+1:2];

  // Writes only happen outside RUN, so a fetch never collides with a write;
  // a fetch accepted alongside ld_start sees the pre-load contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd     <= '0;
      r_rvalid <= 1'b0;
      r_fault  <= 2'b00;
    end else begin
      r_rvalid <= w_acc;
      if (w_acc) begin
        r_fault <= w_fault;
        r_rd    <= (w_fault == 2'b00) ? r_mem[w_ridx] : FILL;
      end
    end
  end

  assign f_ready  = r_fready;
  assign ld_ready = r_ldready;
  assign busy     = r_busy;
  assign RD       = r_rd;
  assign f_rvalid = r_rvalid;
  assign f_fault  = r_fault;
endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, synchronous instruction memory for the RISC-V core. It is the successor to the fixed, combinational program ROM.
- After reset it fills itself with NOPs.
- It accepts a program image over a streaming load port with a valid/ready handshake.
- It serves fetches with one-cycle registered latency and flags misaligned or out-of-range fetch addresses.
- It sits between the PC/fetch stage and a host or test loader.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words; power of two, ≥ 4.
- AW, 32: width of the fetch byte address.
- FILL, 32'h0000_0013: fill word (addi x0,x0,0) written by CLEAR and returned on faults.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request.
- A  in  AW  fetch byte address.
- f_ready  out  1  fetch can be accepted (state RUN).
- RD  out  32  fetched instruction, registered.
- f_rvalid  out  1  RD/f_fault valid for exactly one cycle.
- f_fault  out  2  00 ok, 01 misaligned (A[1:0]≠0), 10 out of range (A ≥ 4·DEPTH); misaligned wins if both apply.
- ld_start  in  1  pulse; begin program load at word 0.
- ld_valid  in  1  load beat valid.
- ld_data  in  32  load word.
- ld_last  in  1  final beat of image.
- ld_ready  out  1  load beat can be accepted (state LOAD).
- busy  out  1  state ≠ RUN.

## Operation
- Storage: DEPTH×32 array, one write port, one registered read port. The write pointer wp has log2(DEPTH) bits.
- FSM states are CLEAR, RUN and LOAD.
  - CLEAR: each cycle writes FILL at wp and increments wp. When wp = DEPTH−1 is written, wp ← 0 and the FSM goes to RUN.
  - RUN: fetches are served. If ld_start = 1, wp ← 0 and the FSM goes to LOAD.
  - LOAD: each beat (ld_valid & ld_ready) writes ld_data at wp and increments wp. A beat with ld_last = 1, or the beat at wp = DEPTH−1, ends the load: wp ← 0 and the FSM goes to RUN. Words beyond the last beat keep their previous contents.
- ld_start is ignored in CLEAR and LOAD.
- ld_ready = (state = LOAD); there is no backpressure within LOAD.
- ld_valid outside LOAD has no effect.
- Fetch acceptance: f_req & f_ready.
  - On acceptance with f_fault = 00: RD ← mem[A[log2(DEPTH)+1:2]].
  - On acceptance with a fault: RD ← FILL and f_fault is set.
  - In both cases f_rvalid = 1 on the next cycle.
- With no accepted fetch, f_rvalid = 0 and RD and f_fault hold their last values.
- f_req while f_ready = 0 is not accepted and is not queued; the requester holds it.
- Simultaneous ld_start and f_req in RUN: the fetch is accepted and returns the pre-load contents, and the FSM enters LOAD next cycle.
- Reset mid-operation: all state clears immediately and a full CLEAR re-runs; a partially loaded image is discarded.

## Timing
- Values while rst_n = 0: state = CLEAR, wp = 0, RD = 0, f_rvalid = 0, f_fault = 00, f_ready = 0, ld_ready = 0, busy = 1.
- CLEAR length: exactly DEPTH rising edges after rst_n deasserts. f_ready = 1 from the cycle after the DEPTH-th edge.
- Fetch latency: 1 cycle, with throughput 1 fetch per cycle in RUN.
- A beat accepted on edge n is readable by a fetch accepted on any edge after the FSM has returned to RUN. The last beat's edge also performs the LOAD→RUN transition, so the earliest such fetch is accepted on edge n+1.
- busy and f_ready are registered state decodes; they change on the edge that changes state.

## Test plan
- Reset, then wait (DEPTH = 64): busy = 1 for 64 cycles, then f_ready = 1. Fetches of A = 0, 4, 252 all return RD = 32'h0000_0013 with f_fault = 00.
- Load 4 words (0x00402083, 0x00802103, 0x001101B3, 0x00302623) with ld_last on the 4th; then fetch A = 0, 4, 8, 12, 16, one per cycle.
  - RD returns those four words in order, then 0x00000013.
  - f_rvalid is high 5 consecutive cycles.
- Fetch A = 0x6, then A = 0x100, then A = 0x102 (DEPTH = 64): f_fault = 01, 10, 01 respectively, RD = FILL each time.
- Assert ld_start and f_req at A = 8 in the same cycle, after a prior load: RD returns the old word 0x001101B3, and ld_ready = 1 on the following cycle.
- Load 70 beats with ld_last never asserted (DEPTH = 64):
  - Load auto-ends after beat 64 and ld_ready drops.
  - Beats 65–70 are not accepted.
  - A fetch at A = 252 returns beat 64's data.
- Pulse rst_n low mid-LOAD after 10 beats: outputs return to their reset values immediately, CLEAR runs 64 cycles, and a fetch at A = 0 then returns FILL.
